// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: slave state encodings, default standard-speed
// timing (microseconds) and the microsecond-to-cycle conversion helper.
package one_wire_pkg;

    // Slave FSM encodings
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SLOT       = 3'd1;
    localparam logic [2:0] S_RECOVER    = 3'd2;
    localparam logic [2:0] S_RST_LOW    = 3'd3;
    localparam logic [2:0] S_PRES_WAIT  = 3'd4;
    localparam logic [2:0] S_PRES_DRIVE = 3'd5;

    // Default standard-speed timing, in microseconds
    localparam int T_RSTDET_US_DEF = 400;
    localparam int T_PDH_US_DEF    = 30;
    localparam int T_PDL_US_DEF    = 120;
    localparam int T_SAMPLE_US_DEF = 30;
    localparam int T_DRIVE_US_DEF  = 30;

    // Whole microseconds to clock cycles for a clock of clk_freq Hz
    function automatic int us_to_cycles(input int us, input int clk_freq);
        return (clk_freq / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/one_wire_slave.sv
// 1-Wire responder (standard speed): detects bus reset and answers with a
// presence pulse, assembles master write slots into bytes (LSB first) and
// answers master read slots from a byte accepted over valid/ready.
module one_wire_slave
    import one_wire_pkg::*;
#(
    parameter int CLK_FREQ    = 60_000_000,
    parameter int T_RSTDET_US = T_RSTDET_US_DEF,
    parameter int T_PDH_US    = T_PDH_US_DEF,
    parameter int T_PDL_US    = T_PDL_US_DEF,
    parameter int T_SAMPLE_US = T_SAMPLE_US_DEF,
    parameter int T_DRIVE_US  = T_DRIVE_US_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        onewire_io,
    output logic       bus_reset,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam logic [19:0] RST_CYC    = 20'(us_to_cycles(T_RSTDET_US, CLK_FREQ));
    localparam logic [19:0] PDH_CYC    = 20'(us_to_cycles(T_PDH_US, CLK_FREQ));
    localparam logic [19:0] PDL_CYC    = 20'(us_to_cycles(T_PDL_US, CLK_FREQ));
    localparam logic [19:0] SAMPLE_CYC = 20'(us_to_cycles(T_SAMPLE_US, CLK_FREQ));
    localparam logic [19:0] DRIVE_CYC  = 20'(us_to_cycles(T_DRIVE_US, CLK_FREQ));

    logic [2:0]  state;
    logic [19:0] cnt;
    logic [19:0] low_cnt;
    logic [1:0]  sync_ff;
    logic        bus_prev;
    logic        drive_low;
    logic        slot_is_read;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_idx;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_idx;
    logic        tx_loaded;

    logic bus_s;
    logic fall;
    logic rst_det;
    logic tx_accept;

    // Open-drain: only ever pull low; reset value of drive_low releases the bus
    assign onewire_io = drive_low ? 1'b0 : 1'bz;

    assign bus_s     = sync_ff[1];
    assign fall      = bus_prev & ~bus_s;
    assign rst_det   = (state != S_PRES_DRIVE) && (low_cnt == RST_CYC);
    assign tx_ready  = (state == S_IDLE) && !tx_loaded;
    assign tx_accept = tx_valid && tx_ready;
    assign busy      = (state != S_IDLE);

    // Two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= 2'b11;
            bus_prev <= 1'b1;
        end else begin
            sync_ff  <= {sync_ff[0], onewire_io};
            bus_prev <= bus_s;
        end
    end

    // Consecutive synced-low cycles, saturating so a stuck bus never re-triggers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            low_cnt <= '0;
        else if (bus_s)
            low_cnt <= '0;
        else if (low_cnt != '1)
            low_cnt <= low_cnt + 20'd1;
    end

    // Slot / reset / presence FSM with rx assembly and tx serialization
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            drive_low    <= 1'b0;
            slot_is_read <= 1'b0;
            rx_shift     <= '0;
            rx_idx       <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            bus_reset    <= 1'b0;
            tx_shift     <= '0;
            tx_idx       <= '0;
            tx_loaded    <= 1'b0;
        end else begin
            bus_reset <= 1'b0;
            rx_valid  <= 1'b0;
            if (cnt != '1)
                cnt <= cnt + 20'd1;

            if (tx_accept) begin
                tx_shift  <= tx_data;
                tx_loaded <= 1'b1;
                tx_idx    <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_SLOT;
                        cnt   <= '0;
                        // Pre-accept value: a byte loaded this cycle makes it a write slot
                        slot_is_read <= tx_loaded;
                        if (tx_loaded && !tx_shift[0])
                            drive_low <= 1'b1;
                    end
                end
                S_SLOT: begin
                    if (slot_is_read) begin
                        if (cnt == DRIVE_CYC) begin
                            drive_low <= 1'b0;
                            tx_shift  <= {1'b0, tx_shift[7:1]};
                            tx_idx    <= tx_idx + 3'd1;
                            if (tx_idx == 3'd7)
                                tx_loaded <= 1'b0;
                            state <= S_RECOVER;
                            cnt   <= '0;
                        end
                    end else if (cnt == SAMPLE_CYC) begin
                        rx_shift <= {bus_s, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) begin
                            rx_data  <= {bus_s, rx_shift[7:1]};
                            rx_valid <= 1'b1;
                        end
                        state <= S_RECOVER;
                        cnt   <= '0;
                    end
                end
                S_RECOVER: begin
                    if (bus_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                S_RST_LOW: begin
                    if (bus_s) begin
                        state <= S_PRES_WAIT;
                        cnt   <= '0;
                    end
                end
                S_PRES_WAIT: begin
                    if (cnt == PDH_CYC - 20'd1) begin
                        drive_low <= 1'b1;
                        state     <= S_PRES_DRIVE;
                        cnt       <= '0;
                    end
                end
                S_PRES_DRIVE: begin
                    if (cnt == PDL_CYC - 20'd1) begin
                        drive_low <= 1'b0;
                        state     <= S_RECOVER;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase

            // Bus reset overrides any slot activity in the same cycle
            if (rst_det) begin
                bus_reset <= 1'b1;
                rx_idx    <= '0;
                rx_shift  <= '0;
                tx_loaded <= 1'b0;
                tx_idx    <= '0;
                drive_low <= 1'b0;
                state     <= S_RST_LOW;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_one_wire_slave.sv
// Bench for one_wire_slave: behavioural 1-Wire master on a pulled-up bus,
// scoreboard of expected bus_reset / rx_valid events, direct read-slot checks.
`timescale 1ns/1ps
module tb_one_wire_slave;

    localparam int CLK_FREQ = 10_000_000;   // 10 cycles per microsecond keeps runtime short
    localparam int US       = CLK_FREQ / 1_000_000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       bus_reset, rx_valid, tx_ready, busy;
    logic [7:0] rx_data;
    wire        onewire;

    assign onewire = m_low ? 1'b0 : 1'bz;
    pullup (onewire);

    always #50 clk = ~clk;

    one_wire_slave #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .onewire_io (onewire),
        .bus_reset  (bus_reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    typedef struct packed {
        logic       is_rx;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Monitor: every DUT event must match the head of the expectation queue
    task automatic mon_pop(input logic is_rx, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got rx=%0d data=%h, required no event", is_rx, d);
        end else begin
            e = exp_q.pop_front();
            if (e.is_rx !== is_rx || (is_rx && e.data !== d)) begin
                errors++;
                $display("FAIL event: got rx=%0d data=%h, required rx=%0d data=%h",
                         is_rx, d, e.is_rx, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_reset) mon_pop(1'b0, 8'h00);
            if (rx_valid)  mon_pop(1'b1, rx_data);
        end
    end

    task automatic wait_us(input int n);
        repeat (n * US) @(negedge clk);
    endtask

    // Write slot; for a 1 bit also confirm nobody holds the bus low
    task automatic write_bit(input logic b);
        m_low = 1'b1;
        wait_us(b ? 6 : 60);
        m_low = 1'b0;
        if (b) begin
            wait_us(14);
            chk("write1_bus_free", onewire, 1'b1);
            wait_us(50);
        end else begin
            wait_us(10);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) write_bit(d[i]);
    endtask

    task automatic read_bit(input logic exp);
        m_low = 1'b1;
        wait_us(2);
        m_low = 1'b0;
        wait_us(11);
        chk("read_bit", onewire, exp);
        wait_us(57);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        chk("tx_ready_before_load", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_after_load", tx_ready, 1'b0);
    endtask

    // 480 us reset, then measure the presence pulse over a 200 us window
    task automatic bus_rst_seq();
        int first, len;
        exp_q.push_back('{is_rx: 1'b0, data: 8'h00});
        m_low = 1'b1;
        wait_us(480);
        m_low = 1'b0;
        first = -1;
        len   = 0;
        for (int i = 0; i < 200 * US; i++) begin
            @(negedge clk);
            if (onewire === 1'b0) begin
                if (first < 0) first = i;
                len++;
            end
        end
        chk_range("presence_start", first, 30 * US, 30 * US + 6);
        chk_range("presence_len", len, 120 * US - 2, 120 * US + 2);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_bus_released", onewire, 1'b1);
        chk("rst_bus_reset", bus_reset, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_us(10);

        // Bus reset and presence
        bus_rst_seq();
        wait_us(10);

        // Write 0xA5
        exp_q.push_back('{is_rx: 1'b1, data: 8'hA5});
        write_byte(8'hA5);
        wait_us(10);

        // Read 0x3C back: bits 0,0,1,1,1,1,0,0
        load_tx(8'h3C);
        wait_us(5);
        read_bit(1'b0); read_bit(1'b0); read_bit(1'b1); read_bit(1'b1);
        read_bit(1'b1); read_bit(1'b1); read_bit(1'b0); read_bit(1'b0);
        wait_us(5);
        chk("tx_ready_after_8_reads", tx_ready, 1'b1);

        // Partial byte discarded by bus reset, then 0x55
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
        bus_rst_seq();
        wait_us(10);
        exp_q.push_back('{is_rx: 1'b1, data: 8'h55});
        write_byte(8'h55);
        wait_us(10);

        // Loaded tx byte dropped by bus reset; next slot is a write slot
        load_tx(8'h00);
        wait_us(5);
        bus_rst_seq();
        chk("tx_ready_after_reset_drop", tx_ready, 1'b1);
        write_bit(1'b1);
        wait_us(10);

        // Async reset while the slave drives presence
        exp_q.push_back('{is_rx: 1'b0, data: 8'h00});
        m_low = 1'b1;
        wait_us(480);
        m_low = 1'b0;
        wait_us(60);
        chk("presence_driving", onewire, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_bus_released", onewire, 1'b1);
        chk("async_rst_bus_reset", bus_reset, 1'b0);
        chk("async_rst_rx_valid", rx_valid, 1'b0);
        chk("async_rst_rx_data", rx_data, 8'h00);
        chk("async_rst_tx_ready", tx_ready, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_us(10);
        bus_rst_seq();
        wait_us(20);

        chk("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
